// File: rtl/hfrv_retire_trace.sv
`default_nettype none
// ============================================================================
// Module   : hfrv_retire_trace
// Purpose  : Retirement trace FIFO feeding the verification monitor stream;
//            overflow drops records (counted) instead of stalling the core.
// Revision : 1.0
// ============================================================================
module hfrv_retire_trace #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trace_en,
    input  logic                     retire_valid,
    input  logic [31:0]              retire_pc,
    input  logic [31:0]              retire_instr,
    input  logic [4:0]               retire_rd,
    input  logic                     retire_we,
    input  logic [31:0]              retire_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [4:0]               out_rd,
    output logic                     out_we,
    output logic [31:0]              out_wdata,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [CNT_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam int              c_rec_w   = SEQ_W + 32 + 32 + 5 + 1 + 32;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [c_rec_w-1:0] r_mem [DEPTH];
    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [SEQ_W-1:0]   r_seq;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_count;

    logic               w_capture;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_we_norm;
    logic [c_rec_w-1:0] w_rec;
    logic [c_rec_w-1:0] w_head;

    assign w_capture = trace_en && retire_valid;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]) &&
                       (r_wptr[c_aw] != r_rptr[c_aw]);
    assign w_pop     = !w_empty && out_ready;
    // A full FIFO still accepts the new record when the head leaves this cycle.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    // Writes to x0 are architecturally invisible, so they are recorded as no-writes.
    assign w_we_norm = retire_we && (retire_rd != 5'd0);
    assign w_rec     = {r_seq, retire_pc, retire_instr, retire_rd, w_we_norm,
                        w_we_norm ? retire_wdata : 32'd0};

    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= w_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_capture) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (overflow_clr) begin
                    r_drop_count <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (r_drop_count != c_cnt_max) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end else if (overflow_clr) begin
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end
        end
    end

    assign w_head = r_mem[r_rptr[c_aw-1:0]];
    assign {out_seq, out_pc, out_instr, out_rd, out_we, out_wdata} = w_head;

    assign out_valid  = !w_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign level      = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: tb/tb_hfrv_retire_trace.sv
`default_nettype none
// ============================================================================
// Module   : tb_hfrv_retire_trace
// Purpose  : Directed scoreboard bench for hfrv_retire_trace.
// Revision : 1.0
// ============================================================================
module tb_hfrv_retire_trace;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;
    localparam int CNT_W = 16;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_en;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic [4:0]  retire_rd;
    logic        retire_we;
    logic [31:0] retire_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_seq;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [31:0] out_wdata;
    logic        overflow;
    logic        overflow_clr;
    logic [15:0] drop_count;
    logic [3:0]  level;

    int compared   = 0;
    int mismatched = 0;

    rec_t        q[$];
    logic [15:0] m_seq;
    logic        m_ovf;
    logic [15:0] m_dc;
    bit          m_init = 0;

    hfrv_retire_trace #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .trace_en(trace_en),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_instr(retire_instr), .retire_rd(retire_rd),
        .retire_we(retire_we), .retire_wdata(retire_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
        .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd),
        .out_we(out_we), .out_wdata(out_wdata), .overflow(overflow),
        .overflow_clr(overflow_clr), .drop_count(drop_count), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check the head against the scoreboard, update the model, advance.
    task automatic cycle();
        bit   popm;
        rec_t r;
        #1;
        popm = 0;
        if (m_init) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
            chk("level", {60'd0, level}, 64'(q.size()));
            popm = reset_n && (q.size() != 0) && out_ready;
            if (popm) begin
                chk("out_seq",   {48'd0, out_seq},   {48'd0, q[0].seq});
                chk("out_pc",    {32'd0, out_pc},    {32'd0, q[0].pc});
                chk("out_instr", {32'd0, out_instr}, {32'd0, q[0].instr});
                chk("out_rd",    {59'd0, out_rd},    {59'd0, q[0].rd});
                chk("out_we",    {63'd0, out_we},    {63'd0, q[0].we});
                chk("out_wdata", {32'd0, out_wdata}, {32'd0, q[0].wdata});
            end
        end
        if (!reset_n) begin
            q.delete();
            m_seq  = 16'd0;
            m_ovf  = 1'b0;
            m_dc   = 16'd0;
            m_init = 1;
        end else begin
            bit full;
            bit drop;
            full = (q.size() == DEPTH);
            drop = 0;
            if (popm) void'(q.pop_front());
            if (trace_en && retire_valid) begin
                if (!full || popm) begin
                    r.seq   = m_seq;
                    r.pc    = retire_pc;
                    r.instr = retire_instr;
                    r.rd    = retire_rd;
                    r.we    = retire_we && (retire_rd != 5'd0);
                    r.wdata = r.we ? retire_wdata : 32'd0;
                    q.push_back(r);
                end else begin
                    drop  = 1;
                    m_ovf = 1'b1;
                    if (overflow_clr)          m_dc = 16'd1;
                    else if (m_dc != 16'hffff) m_dc = m_dc + 16'd1;
                end
                m_seq = m_seq + 16'd1;
            end
            if (!drop && overflow_clr) begin
                m_ovf = 1'b0;
                m_dc  = 16'd0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (m_init) begin
            chk("overflow",   {63'd0, overflow},   {63'd0, m_ovf});
            chk("drop_count", {48'd0, drop_count}, {48'd0, m_dc});
        end
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd,
                          input logic we, input logic [31:0] wd);
        trace_en     = 1'b1;
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_instr = 32'h0000_0013 | (32'(rd) << 7) | (pc << 12);
        retire_rd    = rd;
        retire_we    = we;
        retire_wdata = wd;
        cycle();
        retire_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        retire_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset_n = 1'b0; trace_en = 1'b1; retire_valid = 1'b0;
        retire_pc = '0; retire_instr = '0; retire_rd = '0; retire_we = 1'b0;
        retire_wdata = '0; out_ready = 1'b0; overflow_clr = 1'b0;
        @(negedge clk);
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // Back-to-back retires drained immediately.
        out_ready = 1'b1;
        retire(32'h0, 5'd1, 1'b1, 32'h11);
        retire(32'h4, 5'd2, 1'b1, 32'h22);
        retire(32'h8, 5'd3, 1'b0, 32'h33);
        idle(2);

        // Write to x0 is normalised away; a normal write survives.
        retire(32'h100, 5'd0, 1'b1, 32'h5);
        retire(32'h104, 5'd31, 1'b1, 32'hdead_beef);
        idle(2);

        // Overflow with ten retires into an 8-deep FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) retire(32'h200 + 32'(i) * 4, 5'(i + 1), 1'b1, 32'(i));
        idle(1);
        out_ready = 1'b1;
        idle(9);
        retire(32'h300, 5'd7, 1'b1, 32'h77);
        idle(2);

        // Full FIFO with simultaneous capture and pop.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) retire(32'h400 + 32'(i) * 4, 5'd4, 1'b1, 32'(100 + i));
        out_ready = 1'b1;
        retire(32'h4f0, 5'd9, 1'b1, 32'h99);
        out_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        idle(9);

        // Clear alone, then clear colliding with a drop.
        overflow_clr = 1'b1;
        idle(1);
        out_ready = 1'b0;
        overflow_clr = 1'b0;
        for (int i = 0; i < 8; i++) retire(32'h500 + 32'(i) * 4, 5'd5, 1'b0, 32'h0);
        retire(32'h5f0, 5'd5, 1'b1, 32'h1);
        overflow_clr = 1'b1;
        retire(32'h5f4, 5'd5, 1'b1, 32'h2);
        overflow_clr = 1'b0;
        out_ready = 1'b1;
        idle(9);

        // Mid-stream reset discards buffered records and restarts seq.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) retire(32'h600 + 32'(i) * 4, 5'd6, 1'b1, 32'(i));
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        out_ready = 1'b1;
        retire(32'h700, 5'd8, 1'b1, 32'h88);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
